// File: rtl/sync_burst_sched.sv
// Round-robin arbiter granting NREQ requesters bursts of sync pulses from a shared generator.
// Optional RUN watchdog: define SYNC_BURST_SCHED_WDOG_EN.
module sync_burst_sched #(
    parameter int NREQ    = 4,
    parameter int BURST_W = 4,
    parameter int PERIOD  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NREQ-1:0]    req,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               sync_in,
    output logic               start,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int PTR_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || BURST_W < 1 || PERIOD < 1) begin : g_param_check
        $error("sync_burst_sched: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [NREQ-1:0]    r_grant, w_grant_nxt;
    logic [PTR_W-1:0]   r_rr_ptr, w_ptr_nxt;
    logic [BURST_W-1:0] r_cnt, w_cnt_nxt;
    logic [PTR_W-1:0]   w_win;
    logic               w_found;
    int unsigned        w_idx;

`ifdef SYNC_BURST_SCHED_WDOG_EN
    localparam int WDOG_LIM = 2 * PERIOD;
    localparam int WDOG_W   = $clog2(WDOG_LIM + 1);
    logic [WDOG_W-1:0]  r_wdog, w_wdog_nxt;
    logic               r_wdog_hit, w_hit_nxt;
`endif

    // Round-robin scan: first set request at or above rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_idx = (32'(r_rr_ptr) + i) % NREQ;
            if (!w_found && req[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_rr_ptr;
        w_cnt_nxt   = r_cnt;
        start       = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
`ifdef SYNC_BURST_SCHED_WDOG_EN
        w_wdog_nxt  = r_wdog;
        w_hit_nxt   = r_wdog_hit;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = NREQ'(1) << w_win;
                    w_cnt_nxt   = burst_len;
                    w_ptr_nxt   = (w_win == PTR_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
                    w_next      = (burst_len == '0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                start  = en;
                w_next = S_RUN;
`ifdef SYNC_BURST_SCHED_WDOG_EN
                w_wdog_nxt = '0;
`endif
                if (sync_in) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == BURST_W'(1)) w_next = S_DONE;
                end
            end
            S_RUN: begin
                if (sync_in) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == BURST_W'(1)) w_next = S_DONE;
`ifdef SYNC_BURST_SCHED_WDOG_EN
                    w_wdog_nxt = '0;
                end else if (r_wdog == WDOG_W'(WDOG_LIM - 1)) begin
                    w_next    = S_DONE;
                    w_hit_nxt = 1'b1;
                end else begin
                    w_wdog_nxt = r_wdog + 1'b1;
`endif
                end
            end
            S_DONE: begin
                done        = en;
`ifdef SYNC_BURST_SCHED_WDOG_EN
                err         = en & r_wdog_hit;
                w_hit_nxt   = 1'b0;
`endif
                w_grant_nxt = '0;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
`ifdef SYNC_BURST_SCHED_WDOG_EN
            r_wdog     <= '0;
            r_wdog_hit <= 1'b0;
`endif
        end else if (en) begin
            r_state    <= w_next;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
`ifdef SYNC_BURST_SCHED_WDOG_EN
            r_wdog     <= w_wdog_nxt;
            r_wdog_hit <= w_hit_nxt;
`endif
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_sync_burst_sched.sv
// Self-checking bench for sync_burst_sched: vector table, directed corner sequences,
// and randomized traffic against a burst-level reference model.
module tb_sync_burst_sched;

    localparam int NREQ   = 4;
    localparam int BW     = 4;
    localparam int PERIOD = 4;

    logic          clk = 1'b0;
    logic          rst_n, en, sync_in;
    logic [NREQ-1:0] req;
    logic [BW-1:0]   burst_len;
    logic          start, busy, done, err;
    logic [NREQ-1:0] grant;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sync_burst_sched #(.NREQ(NREQ), .BURST_W(BW), .PERIOD(PERIOD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .burst_len(burst_len),
        .sync_in(sync_in), .start(start), .grant(grant), .busy(busy),
        .done(done), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {grant, start, busy, done, err};
    endfunction

    // Reference model: who owns the generator, pulses still owed, and phase flags.
    int m_owner, m_left, m_ptr, m_quiet;
    bit m_fresh, m_closing, m_abort;

    function automatic void model_reset();
        m_owner = -1; m_left = 0; m_ptr = 0; m_quiet = 0;
        m_fresh = 0; m_closing = 0; m_abort = 0;
    endfunction

    function automatic logic [7:0] model_expect();
        logic [NREQ-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, en && m_owner >= 0 && m_fresh, m_owner >= 0,
                en && m_closing, en && m_closing && m_abort};
    endfunction

    function automatic void model_step();
        if (!en) return;
        if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int w;
                w = (m_ptr + k) % NREQ;
                if (req[w]) begin
                    m_owner = w;
                    m_ptr   = (w + 1) % NREQ;
                    m_left  = int'(burst_len);
                    if (m_left == 0) m_closing = 1; else m_fresh = 1;
                    break;
                end
            end
        end else if (m_closing) begin
            m_owner = -1; m_closing = 0; m_abort = 0;
        end else begin
            if (sync_in) begin
                m_left--;
                m_quiet = 0;
                if (m_left == 0) m_closing = 1;
            end else if (m_fresh) begin
                m_quiet = 0;
            end else begin
                m_quiet++;
`ifdef SYNC_BURST_SCHED_WDOG_EN
                if (m_quiet == 2 * PERIOD) begin
                    m_closing = 1;
                    m_abort   = 1;
                end
`endif
            end
            m_fresh = 0;
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; req = '0; burst_len = '0; sync_in = 1'b0;
        #3;
        check("reset_outputs", 32'(outs()), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic [BW-1:0]   bl;
        logic            sync;
        logic            en;
        logic [NREQ-1:0] grant;
        logic            start, busy, done;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [3:0] r, input logic [3:0] b, input logic s, input logic e,
                       input logic [3:0] g, input logic st, input logic bz, input logic dn);
        vec_t v;
        v.req = r; v.bl = b; v.sync = s; v.en = e;
        v.grant = g; v.start = st; v.busy = bz; v.done = dn;
        tv.push_back(v);
    endtask

    logic [NREQ-1:0] rr_exp [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

    initial begin
        tick();
        do_reset();

        // Single burst of 3 with a period-4 generator, then burst_len=0, then rr_ptr check.
        add(4'b0001, 3, 0, 1, 4'b0000, 0, 0, 0);
        add(4'b0000, 0, 1, 1, 4'b0001, 1, 1, 0);
        repeat (3) add(4'b0000, 0, 0, 1, 4'b0001, 0, 1, 0);
        add(4'b0000, 0, 1, 1, 4'b0001, 0, 1, 0);
        repeat (3) add(4'b0000, 0, 0, 1, 4'b0001, 0, 1, 0);
        add(4'b0000, 0, 1, 1, 4'b0001, 0, 1, 0);
        add(4'b0000, 0, 0, 1, 4'b0001, 0, 1, 1);
        add(4'b0000, 0, 0, 1, 4'b0000, 0, 0, 0);
        add(4'b0100, 0, 0, 1, 4'b0000, 0, 0, 0);
        add(4'b0000, 0, 0, 1, 4'b0100, 0, 1, 1);
        add(4'b0000, 0, 0, 1, 4'b0000, 0, 0, 0);
        add(4'b1001, 1, 0, 0, 4'b0000, 0, 0, 0);
        add(4'b0000, 0, 0, 1, 4'b0000, 0, 0, 0);
        add(4'b1001, 1, 0, 1, 4'b0000, 0, 0, 0);
        add(4'b0000, 0, 1, 1, 4'b1000, 1, 1, 0);
        add(4'b0000, 0, 0, 1, 4'b1000, 0, 1, 1);
        add(4'b0000, 0, 0, 1, 4'b0000, 0, 0, 0);
        for (int i = 0; i < tv.size(); i++) begin
            req = tv[i].req; burst_len = tv[i].bl; sync_in = tv[i].sync; en = tv[i].en;
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({tv[i].grant, tv[i].start, tv[i].busy, tv[i].done, 1'b0}));
            tick();
        end

        // Round robin with req=1011 held, single-pulse bursts.
        do_reset();
        req = 4'b1011; burst_len = 1; sync_in = 1'b1;
        begin
            int got;
            bit gap_pending;
            got = 0; gap_pending = 0;
            for (int c = 0; c < 40 && got < 4; c++) begin
                @(negedge clk);
                if (gap_pending) begin
                    check("rr_idle_gap", 32'(busy), 32'h0);
                    gap_pending = 0;
                end
                if (start) begin
                    check($sformatf("rr_grant%0d", got), 32'(grant), 32'(rr_exp[got]));
                    got++;
                end
                if (done) gap_pending = 1;
                tick();
            end
            check("rr_count", 32'(got), 32'd4);
        end

        // en gating during RUN with pulses present.
        do_reset();
        req = 4'b0001; burst_len = 3; sync_in = 1'b0;
        tick();
        req = '0; sync_in = 1'b1;
        tick();
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("en_freeze", 32'(outs()), 32'({4'b0001, 1'b0, 1'b1, 1'b0, 1'b0}));
            tick();
        end
        en = 1'b1; sync_in = 1'b1;
        @(negedge clk); check("en_resume1", 32'(done), 32'h0); tick();
        sync_in = 1'b0;
        @(negedge clk); check("en_resume2", 32'(done), 32'h0); tick();
        sync_in = 1'b1;
        @(negedge clk); check("en_resume3", 32'(done), 32'h0); tick();
        sync_in = 1'b0;
        @(negedge clk); check("en_done", 32'(outs()), 32'({4'b0001, 1'b0, 1'b1, 1'b1, 1'b0})); tick();
        @(negedge clk); check("en_idle", 32'(busy), 32'h0); tick();

        // Asynchronous reset between edges mid-RUN.
        do_reset();
        req = 4'b0010; burst_len = 5; sync_in = 1'b0;
        tick();
        req = '0; sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'({grant, busy, start, done}), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        req = 4'b1111; burst_len = 1;
        @(negedge clk); check("post_reset_idle", 32'(outs()), 32'h0); tick();
        req = '0; sync_in = 1'b1;
        @(negedge clk); check("post_reset_ptr0", 32'(grant), 32'b0001); tick();
        sync_in = 1'b0;
        tick();

        // Watchdog: pulses stop after START with burst_len=5.
        do_reset();
        req = 4'b0001; burst_len = 5; sync_in = 1'b0;
        tick();
        req = '0; sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
`ifdef SYNC_BURST_SCHED_WDOG_EN
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("wdog_wait", 32'({busy, done, err}), 32'b100);
            tick();
        end
        @(negedge clk); check("wdog_abort", 32'({busy, done, err}), 32'b111); tick();
        @(negedge clk); check("wdog_idle", 32'(busy), 32'h0); tick();
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("no_wdog_wait", 32'({busy, done, err}), 32'b100);
            tick();
        end
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en        = ($urandom % 10) != 0;
            req       = ($urandom % 4 == 0) ? '0 : NREQ'($urandom);
            burst_len = BW'($urandom_range(0, 4));
            sync_in   = ($urandom % 3) == 0;
            @(negedge clk);
            check("random", 32'(outs()), 32'(model_expect()));
            model_step();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
